// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter
//  Description : Shares the register file's single write port between the
//                ALU writeback path (A) and the load-data path (B). The two
//                requesters use valid/ready handshakes and are arbitrated
//                round-robin. Writes to x0 are accepted but never enabled.
//                The output stage is registered and drives the register file
//                write port directly.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
    parameter int XLEN = 32,
    parameter int RSEL = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,

    input  logic            a_valid,
    input  logic [RSEL-1:0] a_sel,
    input  logic [XLEN-1:0] a_data,
    output logic            a_ready,

    input  logic            b_valid,
    input  logic [RSEL-1:0] b_sel,
    input  logic [XLEN-1:0] b_data,
    output logic            b_ready,

    output logic [XLEN-1:0] d,
    output logic [RSEL-1:0] dsel,
    output logic            wen,
    output logic            prio
);

    localparam logic [RSEL-1:0] C_X0 = '0;

    // Registered output stage and round-robin pointer
    logic [XLEN-1:0] r_d;
    logic [RSEL-1:0] r_dsel;
    logic            r_wen;
    logic            r_prio;

    // Grant decode
    logic            w_open;
    logic            w_contend;
    logic            w_grant_a;
    logic            w_grant_b;
    logic            w_grant_any;
    logic [XLEN-1:0] w_win_data;
    logic [RSEL-1:0] w_win_sel;

    // Combinational grant: nothing is accepted during reset or stall; with
    // both sides valid the pointer picks the winner, otherwise the lone
    // requester wins. The two grants are mutually exclusive by construction.
    always_comb begin
        w_open      = !rst && !stall;
        w_contend   = a_valid && b_valid;
        w_grant_a   = w_open && a_valid && (!b_valid || !r_prio);
        w_grant_b   = w_open && b_valid && (!a_valid ||  r_prio);
        w_grant_any = w_grant_a || w_grant_b;
        w_win_data  = w_grant_b ? b_data : a_data;
        w_win_sel   = w_grant_b ? b_sel  : a_sel;
    end

    // Output stage: capture the winner; a select of x0 completes the
    // handshake but leaves the write enable low so x0 is never written.
    // Without a grant, data and select hold and only the enable drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_d    <= '0;
            r_dsel <= '0;
            r_wen  <= 1'b0;
        end else begin
            r_wen <= 1'b0;
            if (w_grant_any) begin
                r_d    <= w_win_data;
                r_dsel <= w_win_sel;
                r_wen  <= (w_win_sel != C_X0);
            end
        end
    end

    // Round-robin pointer: flips only when a contended cycle produced a
    // grant, so the loser is favoured next time. Idle, uncontended and
    // stalled cycles leave it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio <= 1'b0;
        end else if (w_contend && w_grant_any) begin
            r_prio <= ~r_prio;
        end
    end

    assign a_ready = w_grant_a;
    assign b_ready = w_grant_b;
    assign d       = r_d;
    assign dsel    = r_dsel;
    assign wen     = r_wen;
    assign prio    = r_prio;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_arbiter
//  Description : Directed self-checking bench for wb_arbiter. A behavioural
//                model (last-contention-winner bookkeeping plus an expected
//                write-port image) is checked against the DUT every cycle,
//                and directed scenarios pin specific literal values,
//                including a register file image written by the DUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

    localparam int XLEN = 32;
    localparam int RSEL = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            stall;
    logic            a_valid, b_valid;
    logic [RSEL-1:0] a_sel, b_sel;
    logic [XLEN-1:0] a_data, b_data;
    logic            a_ready, b_ready;
    logic [XLEN-1:0] d;
    logic [RSEL-1:0] dsel;
    logic            wen;
    logic            prio;

    int n_cmp = 0;
    int n_bad = 0;

    wb_arbiter #(.XLEN(XLEN), .RSEL(RSEL)) dut (
        .clk     (clk),
        .rst     (rst),
        .stall   (stall),
        .a_valid (a_valid),
        .a_sel   (a_sel),
        .a_data  (a_data),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_sel   (b_sel),
        .b_data  (b_data),
        .b_ready (b_ready),
        .d       (d),
        .dsel    (dsel),
        .wen     (wen),
        .prio    (prio)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register file image: captures on the same edge as the real one, and
    // ignores the port while reset is held.
    logic [XLEN-1:0] rf [32];
    always @(posedge clk) begin
        if (wen && !rst) rf[dsel] <= d;
    end

    // ---------------- behavioural model ----------------
    // m_favour_b: whoever lost the most recent contended grant is favoured.
    logic            m_known = 1'b0;
    logic            m_favour_b;
    logic [XLEN-1:0] m_d;
    logic [RSEL-1:0] m_dsel;
    logic            m_wen;

    function automatic logic want_a();
        return !rst && !stall && a_valid && (!b_valid || !m_favour_b);
    endfunction
    function automatic logic want_b();
        return !rst && !stall && b_valid && (!a_valid || m_favour_b);
    endfunction

    always @(posedge clk) begin
        logic ga, gb;
        if (rst) begin
            m_known    = 1'b1;
            m_favour_b = 1'b0;
            m_d        = '0;
            m_dsel     = '0;
            m_wen      = 1'b0;
        end else if (m_known) begin
            ga    = want_a();
            gb    = want_b();
            m_wen = 1'b0;
            if (ga) begin
                m_d = a_data; m_dsel = a_sel; m_wen = (a_sel != 0);
            end else if (gb) begin
                m_d = b_data; m_dsel = b_sel; m_wen = (b_sel != 0);
            end
            if (a_valid && b_valid && (ga || gb)) m_favour_b = ga;
        end
    end

    // Compare process, on the falling edge.
    always @(negedge clk) begin
        if (m_known) begin
            chk("a_ready", {31'b0, a_ready}, {31'b0, want_a()});
            chk("b_ready", {31'b0, b_ready}, {31'b0, want_b()});
            chk("wen",     {31'b0, wen},     {31'b0, m_wen});
            chk("prio",    {31'b0, prio},    {31'b0, m_favour_b});
            chk("d",       d,                m_d);
            chk("dsel",    {27'b0, dsel},    {27'b0, m_dsel});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [RSEL-1:0] exp_dsel [4];

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        exp_dsel[0] = 5'd2; exp_dsel[1] = 5'd3; exp_dsel[2] = 5'd2; exp_dsel[3] = 5'd3;

        // Reset with both requesters valid
        rst = 1'b1; stall = 1'b0;
        a_valid = 1'b1; a_sel = 5'd7; a_data = 32'h77;
        b_valid = 1'b1; b_sel = 5'd8; b_data = 32'h88;
        tick(); #3;
        chk("rst a_ready", {31'b0, a_ready}, 32'd0);
        chk("rst b_ready", {31'b0, b_ready}, 32'd0);
        chk("rst d", d, 32'd0);
        chk("rst dsel", {27'b0, dsel}, 32'd0);
        chk("rst wen", {31'b0, wen}, 32'd0);
        chk("rst prio", {31'b0, prio}, 32'd0);
        tick();
        chk("rst2 a_ready", {31'b0, a_ready}, 32'd0);
        rst = 1'b0; #3;
        chk("first grant A", {31'b0, a_ready}, 32'd1);
        chk("first grant not B", {31'b0, b_ready}, 32'd0);

        // A accepted; A presents a new request, B still waiting -> B wins
        tick(); a_sel = 5'd9; a_data = 32'h99; #3;
        chk("A wrote dsel", {27'b0, dsel}, 32'd7);
        chk("A wrote d", d, 32'h77);
        chk("prio after A", {31'b0, prio}, 32'd1);
        chk("B favoured", {31'b0, b_ready}, 32'd1);
        tick(); b_valid = 1'b0; #3;
        chk("B wrote dsel", {27'b0, dsel}, 32'd8);
        chk("prio after B", {31'b0, prio}, 32'd0);
        tick(); a_valid = 1'b0; #3;
        chk("A2 wrote dsel", {27'b0, dsel}, 32'd9);

        // Single writer to x1
        tick(); a_valid = 1'b1; a_sel = 5'd1; a_data = 32'h1234; #3;
        chk("single a_ready", {31'b0, a_ready}, 32'd1);
        tick(); a_valid = 1'b0; #3;
        chk("single wen", {31'b0, wen}, 32'd1);
        chk("single dsel", {27'b0, dsel}, 32'd1);
        chk("single d", d, 32'h1234);
        tick(); #3;
        chk("rf x1", rf[1], 32'h1234);

        // x0 drop
        b_valid = 1'b1; b_sel = 5'd0; b_data = 32'h1234; #1;
        chk("x0 b_ready", {31'b0, b_ready}, 32'd1);
        tick(); b_valid = 1'b0; #3;
        chk("x0 wen", {31'b0, wen}, 32'd0);
        tick(); #3;
        chk("rf x0", rf[0], 32'd0);

        // Contention for 4 grants
        a_valid = 1'b1; a_sel = 5'd2; a_data = 32'hAAAA;
        b_valid = 1'b1; b_sel = 5'd3; b_data = 32'hBBBB;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("cont prio", {31'b0, prio}, k % 2);
            chk("cont a_ready", {31'b0, a_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            tick(); #3;
            chk("cont dsel", {27'b0, dsel}, {27'b0, exp_dsel[k]});
        end
        a_valid = 1'b0; b_valid = 1'b0;
        chk("cont prio end", {31'b0, prio}, 32'd0);

        // Stall for 2 cycles with A valid
        tick();
        stall = 1'b1; a_valid = 1'b1; a_sel = 5'd5; a_data = 32'h5A;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("stall a_ready", {31'b0, a_ready}, 32'd0);
            tick(); #3;
            chk("stall wen", {31'b0, wen}, 32'd0);
            chk("stall prio", {31'b0, prio}, 32'd0);
        end
        stall = 1'b0; #1;
        chk("unstall a_ready", {31'b0, a_ready}, 32'd1);
        tick(); a_valid = 1'b0; #3;
        chk("unstall wen", {31'b0, wen}, 32'd1);
        chk("unstall dsel", {27'b0, dsel}, 32'd5);

        // Reset mid-write
        tick(); a_valid = 1'b1; a_sel = 5'd4; a_data = 32'h55; #1;
        chk("midrst a_ready", {31'b0, a_ready}, 32'd1);
        tick(); a_valid = 1'b0; rst = 1'b1; #3;
        chk("midrst wen N", {31'b0, wen}, 32'd1);
        tick(); #3;
        chk("midrst wen N+1", {31'b0, wen}, 32'd0);
        rst = 1'b0;
        tick(); tick(); #3;
        chk("rf x4", rf[4], 32'd0);
        chk("post rst dsel", {27'b0, dsel}, 32'd0);

        tick(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
